// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction field positions and fetch states shared by fetch, decode and the sign extender
package cpu_pkg;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {FETCH, HOLD, HALTED} fetch_state_t;
endpackage

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: req/ready instruction-memory bus between the fetch stage (master) and memory (slave)
interface instr_fetch_stage_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master(output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave(input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_counter.sv
// pc_counter: program counter with branch load, increment on capture, and async reset to RESET_PC
module pc_counter #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                inc,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc
);
    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= RESET_PC;
        else if (load) pc <= target;
        else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, imem req/ready handshake, IR capture and field split with stall, branch flush and HALT
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = 16,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_stage_if.master    imem,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [3:0]             if_opcode,
    output logic [3:0]             if_rd,
    output logic [3:0]             if_rs,
    output logic [3:0]             if_imm4,
    output logic                   halted
);
    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic                capture;
    logic                consume;
    logic                is_halt;

    // rst is folded in so the request drops the moment reset asserts
    assign imem.imem_req  = (state == FETCH) & (!if_valid | !stall) & !rst;
    assign imem.imem_addr = pc;
    assign capture        = imem.imem_req & imem.imem_ready & !branch_taken;
    assign consume        = if_valid & !stall;
    assign is_halt        = imem.imem_rdata[OPC_HI:OPC_LO] == OP_HALT;

    pc_counter #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .load   (branch_taken),
        .inc    (capture),
        .target (branch_target),
        .pc     (pc)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= FETCH;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            halted   <= 1'b0;
        end else if (branch_taken) begin
            state    <= FETCH;
            if_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (capture) begin
            if_instr <= imem.imem_rdata;
            if_pc    <= pc;
            if_valid <= 1'b1;
            halted   <= is_halt;
            state    <= is_halt ? HALTED : FETCH;
        end else begin
            if (consume) if_valid <= 1'b0;
            if (state != HALTED) state <= (if_valid & stall) ? HOLD : FETCH;
        end

    assign if_opcode = if_instr[OPC_HI:OPC_LO];
    assign if_rd     = if_instr[RD_HI:RD_LO];
    assign if_rs     = if_instr[RS_HI:RS_LO];
    assign if_imm4   = if_instr[IMM_HI:IMM_LO];
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: vector table plus hand sequences; a queue pairs each captured word with its later consume
module tb_instr_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        if_valid, halted;
    logic [15:0] if_instr, if_pc;
    logic [3:0]  if_opcode, if_rd, if_rs, if_imm4;
    logic        w_valid, w_halted;
    logic [15:0] w_instr, w_pc;
    logic [3:0]  w_opcode, w_rd, w_rs, w_imm4;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        s, r, b;
        logic [15:0] t;
        logic        q, ca;
        logic [15:0] a;
        logic        v;
        logic [15:0] p;
        logic        h;
    } vec_t;
    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];

    instr_fetch_stage_if imem ();
    instr_fetch_stage_if wbus ();

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .clk(clk), .rst(rst), .imem(imem), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_opcode(if_opcode), .if_rd(if_rd), .if_rs(if_rs), .if_imm4(if_imm4),
        .halted(halted)
    );

    instr_fetch_stage #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst(rst), .imem(wbus), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(16'h0000),
        .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc),
        .if_opcode(w_opcode), .if_rd(w_rd), .if_rs(w_rs), .if_imm4(w_imm4),
        .halted(w_halted)
    );

    // Memory image: HALT at 16'h0010, otherwise 16'h1234 plus a per-address offset
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hF000 : 16'h1234 + {a[11:0], 4'h0};
    endfunction

    always_comb imem.imem_rdata = mem_fn(imem.imem_addr);
    always_comb wbus.imem_rdata = mem_fn(wbus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic row(input int s, r, b, t, q, ca, a, v, p, h);
        vec_t x;
        x.s = s[0]; x.r = r[0]; x.b = b[0]; x.t = t[15:0];
        x.q = q[0]; x.ca = ca[0]; x.a = a[15:0];
        x.v = v[0]; x.p = p[15:0]; x.h = h[0];
        tbl.push_back(x);
    endtask

    task automatic step(input logic s, r, b, input logic [15:0] t);
        sb_t e;
        @(negedge clk);
        stall = s;
        imem.imem_ready = r;
        branch_taken = b;
        branch_target = t;
        #1;
        if (if_valid && !stall) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: consume of pc %0h with nothing expected", if_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", {16'h0, if_pc}, {16'h0, e.pc});
                check("sb_instr", {16'h0, if_instr}, {16'h0, e.instr});
            end
        end
        if (b) sb.delete();
        else if (imem.imem_req && r) sb.push_back('{imem.imem_addr, mem_fn(imem.imem_addr)});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'h0, imem.imem_req}, 0);
        check({tag, "_addr"}, {16'h0, imem.imem_addr}, 0);
        check({tag, "_valid"}, {31'h0, if_valid}, 0);
        check({tag, "_instr"}, {16'h0, if_instr}, 0);
        check({tag, "_pc"}, {16'h0, if_pc}, 0);
        check({tag, "_fields"}, {16'h0, if_opcode, if_rd, if_rs, if_imm4}, 0);
        check({tag, "_halted"}, {31'h0, halted}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //  s  r  b  tgt      req ca addr     v  if_pc    h
        row(0, 1, 0, 0,       1, 1, 'h0000,  0, 0,       0);
        row(0, 1, 0, 0,       1, 1, 'h0001,  1, 'h0000,  0);
        row(0, 1, 0, 0,       1, 1, 'h0002,  1, 'h0001,  0);
        row(0, 1, 0, 0,       1, 1, 'h0003,  1, 'h0002,  0);
        row(0, 1, 0, 0,       1, 1, 'h0004,  1, 'h0003,  0);
        row(0, 0, 0, 0,       1, 1, 'h0005,  1, 'h0004,  0);
        row(0, 0, 0, 0,       1, 1, 'h0005,  0, 0,       0);
        row(0, 0, 0, 0,       1, 1, 'h0005,  0, 0,       0);
        row(0, 1, 0, 0,       1, 1, 'h0005,  0, 0,       0);
        row(1, 1, 0, 0,       0, 1, 'h0006,  1, 'h0005,  0);
        row(1, 1, 0, 0,       0, 0, 0,       1, 'h0005,  0);
        row(1, 1, 0, 0,       0, 0, 0,       1, 'h0005,  0);
        row(1, 1, 0, 0,       0, 0, 0,       1, 'h0005,  0);
        row(0, 1, 0, 0,       0, 0, 0,       1, 'h0005,  0);
        row(0, 1, 0, 0,       1, 1, 'h0006,  0, 0,       0);
        row(0, 1, 0, 0,       1, 1, 'h0007,  1, 'h0006,  0);
        row(1, 1, 1, 'h0040,  0, 0, 0,       1, 'h0007,  0);
        row(0, 1, 0, 0,       1, 1, 'h0040,  0, 0,       0);
        row(0, 1, 1, 'h0020,  1, 1, 'h0041,  1, 'h0040,  0);
        row(0, 0, 0, 0,       1, 1, 'h0020,  0, 0,       0);
        row(0, 1, 1, 'h000F,  1, 1, 'h0020,  0, 0,       0);
        row(0, 1, 0, 0,       1, 1, 'h000F,  0, 0,       0);
        row(0, 1, 0, 0,       1, 1, 'h0010,  1, 'h000F,  0);
        row(0, 1, 0, 0,       0, 0, 0,       1, 'h0010,  1);

        imem.imem_ready = 1'b0;
        wbus.imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].r, tbl[i].b, tbl[i].t);
            wbus.imem_ready = (i < 2);
            check($sformatf("row%0d_req", i), {31'h0, imem.imem_req}, {31'h0, tbl[i].q});
            if (tbl[i].ca) check($sformatf("row%0d_addr", i), {16'h0, imem.imem_addr}, {16'h0, tbl[i].a});
            check($sformatf("row%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].v});
            if (tbl[i].v) check($sformatf("row%0d_if_pc", i), {16'h0, if_pc}, {16'h0, tbl[i].p});
            check($sformatf("row%0d_halted", i), {31'h0, halted}, {31'h0, tbl[i].h});
            if (i < 2) check($sformatf("row%0d_wrap_addr", i), {16'h0, wbus.imem_addr}, (i == 0) ? 32'hFFFF : 32'h0);
            if (i == 1) check("fields_1234", {16'h0, if_opcode, if_rd, if_rs, if_imm4}, 32'h1234);
            if (i == 23) check("halt_opcode", {28'h0, if_opcode}, 32'hF);
        end

        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 16'h0);
            check($sformatf("halt%0d_req", i), {31'h0, imem.imem_req}, 0);
            check($sformatf("halt%0d_halted", i), {31'h0, halted}, 1);
        end
        step(0, 1, 1, 16'h0000);
        check("redirect_req", {31'h0, imem.imem_req}, 0);
        check("redirect_halted", {31'h0, halted}, 1);
        step(0, 1, 0, 16'h0);
        check("resume_halted", {31'h0, halted}, 0);
        check("resume_req", {31'h0, imem.imem_req}, 1);
        check("resume_addr", {16'h0, imem.imem_addr}, 0);
        step(0, 0, 0, 16'h0);
        check("resume_valid", {31'h0, if_valid}, 1);
        check("resume_if_pc", {16'h0, if_pc}, 0);
        check("wait_req", {31'h0, imem.imem_req}, 1);
        check("wait_addr", {16'h0, imem.imem_addr}, 1);
        check("wrap_wait_req", {31'h0, wbus.imem_req}, 1);
        check("wrap_wait_addr", {16'h0, wbus.imem_addr}, 1);

        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check_reset_outputs("midreset");
        check("midreset_wrap_req", {31'h0, wbus.imem_req}, 0);
        check("midreset_wrap_addr", {16'h0, wbus.imem_addr}, 32'hFFFF);
        check("midreset_wrap_valid", {31'h0, w_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
